fetch_stage: RTL

//  Instruction fetch stage directly downstream of Pc. Samples pc_in, reads the
//  on-chip instruction memory (1-cycle synchronous read), buffers fetched
//  {pc,instr} pairs in a 2-entry queue, and hands them to decode over a

---
 rtl/fetch_if.sv | 50 +++++
 rtl/fetch_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: Pc control, imem loader port and decode valid/ready handshake.
// Perf counter outputs exist only when FETCH_PERF_EN is defined.
interface fetch_if #(
    parameter int IW  = 8,
    parameter int IMW = 4
);
    logic           start;
    logic [IMW-1:0] pc_in;
    logic           flush;
    logic           pc_hold;
    logic           imem_we;
    logic [IMW-1:0] imem_waddr;
    logic [IW-1:0]  imem_wdata;
    logic           instr_valid;
    logic           instr_ready;
    logic [IW-1:0]  instr_out;
    logic [IMW-1:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [15:0]    perf_fetched;
    logic [15:0]    perf_flushed;

    modport master (
        input  start, pc_in, flush,
        input  imem_we, imem_waddr, imem_wdata,
        input  instr_ready,
        output pc_hold, instr_valid, instr_out, instr_pc,
        output perf_fetched, perf_flushed
    );
    modport slave (
        output start, pc_in, flush,
        output imem_we, imem_waddr, imem_wdata,
        output instr_ready,
        input  pc_hold, instr_valid, instr_out, instr_pc,
        input  perf_fetched, perf_flushed
    );
`else
    modport master (
        input  start, pc_in, flush,
        input  imem_we, imem_waddr, imem_wdata,
        input  instr_ready,
        output pc_hold, instr_valid, instr_out, instr_pc
    );
    modport slave (
        output start, pc_in, flush,
        output imem_we, imem_waddr, imem_wdata,
        output instr_ready,
        input  pc_hold, instr_valid, instr_out, instr_pc
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: sync-read imem, 2-entry {pc,instr} queue, decode handshake.
// FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_stage #(
    parameter int IW  = 8,
    parameter int IMW = 4,
    parameter int DW  = 8
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);
    localparam int DEPTH = 1 << IMW;

    logic [IW-1:0]  r_mem [DEPTH];
    logic           r_rd_valid;
    logic [IMW-1:0] r_rd_pc;
    logic [IW-1:0]  r_rd_instr;
    logic [1:0]     r_count;
    logic [IMW-1:0] r_q_pc    [2];
    logic [IW-1:0]  r_q_instr [2];

    logic       w_pop;
    logic       w_push;
    logic       w_issue;
    logic [2:0] w_occ;

    assign w_pop   = (r_count != 2'd0) & bus.instr_ready;
    assign w_push  = r_rd_valid & ~bus.flush;
    // Occupancy after this edge, ignoring a new issue; keeps room for it.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_rd_valid}
                   - {2'b00, w_pop};
    assign w_issue = bus.start & ~rst & ~bus.flush & (w_occ <= 3'd1);

    assign bus.pc_hold     = ~w_issue;
    assign bus.instr_valid = (r_count != 2'd0);
    assign bus.instr_out   = r_q_instr[0];
    assign bus.instr_pc    = r_q_pc[0];

    // Memory is never reset; a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            r_mem[bus.imem_waddr] <= bus.imem_wdata;
        end
        if (w_issue) begin
            r_rd_pc    <= bus.pc_in;
            r_rd_instr <= r_mem[bus.pc_in];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= 2'd0;
            r_q_pc[0]    <= '0;
            r_q_pc[1]    <= '0;
            r_q_instr[0] <= '0;
            r_q_instr[1] <= '0;
        end else if (bus.flush) begin
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_q_pc[0]    <= r_rd_pc;
                        r_q_instr[0] <= r_rd_instr;
                    end else begin
                        r_q_pc[1]    <= r_rd_pc;
                        r_q_instr[1] <= r_rd_instr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q_pc[0]    <= r_q_pc[1];
                    r_q_instr[0] <= r_q_instr[1];
                    r_count      <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_q_pc[0]    <= r_rd_pc;
                        r_q_instr[0] <= r_rd_instr;
                    end else begin
                        r_q_pc[0]    <= r_q_pc[1];
                        r_q_instr[0] <= r_q_instr[1];
                        r_q_pc[1]    <= r_rd_pc;
                        r_q_instr[1] <= r_rd_instr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 16'd0;
            r_perf_flushed <= 16'd0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 16'd1;
            end
            if (bus.flush && (r_count != 2'd0 || r_rd_valid)) begin
                r_perf_flushed <= r_perf_flushed + 16'd1;
            end
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_flushed = r_perf_flushed;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && r_count == 2'd2 && !w_pop));
    a_dw_legal: assert property (@(posedge clk) DW > 0);
`endif

endmodule
